multi_arb: RTL and testbench

MULTI_ARB -- requirements
Module: multi_arb

---
 rtl/multi_arb.sv | 168 ++++++++++++++++
 tb/tb_multi_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_arb.sv
// -----------------------------------------------------------------------------
// multi_arb -- round-robin arbiter that shares one multiplier core between
// NREQ requesters. One transaction is in flight at a time:
//   IDLE  -> pick a winner, pulse req_ready, latch operands
//   ISSUE -> hold m_valid/m_a/m_b until the core accepts (m_ready)
//   WAIT  -> wait for m_o_valid, capture m_product
//   RESP  -> pulse rsp_valid to the winner, advance the round-robin pointer
//
// Parameters
//   WIDTH  operand width of the core (1..16)
//   NREQ   number of requesters (2..4)
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_a/req_b  per-requester request, operands packed i*WIDTH
//   req_ready              one-hot accept pulse
//   rsp_valid/rsp_data     one-hot result pulse and product (held between)
//   m_valid/m_a/m_b/m_ready      request channel to the core
//   m_o_valid/m_product          result channel from the core
//   busy                   high whenever the FSM is not in IDLE
//   gnt_id                 index of the current or last winner
//   timeout                (MULTI_ARB_TIMEOUT_EN only) watchdog abort pulse
//
// Build option
//   MULTI_ARB_TIMEOUT_EN   adds a watchdog over ISSUE/WAIT that aborts the
//                          transaction after 2*WIDTH+4 cycles in one state.
// -----------------------------------------------------------------------------
module multi_arb #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  m_valid,
    output logic [WIDTH-1:0]      m_a,
    output logic [WIDTH-1:0]      m_b,
    input  logic                  m_ready,
    input  logic                  m_o_valid,
    input  logic [2*WIDTH-1:0]    m_product,
    output logic                  busy,
`ifdef MULTI_ARB_TIMEOUT_EN
    output logic                  timeout,
`endif
    output logic [1:0]            gnt_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic       any_req;
    logic [1:0] win;
    int         idx;

`ifdef MULTI_ARB_TIMEOUT_EN
    localparam int TO_LIMIT = 2*WIDTH + 4;
    localparam int CW       = $clog2(TO_LIMIT);
    logic [CW-1:0] wd_cnt;
`endif

    // Pointer to the requester after id, wrapping at NREQ.
    function automatic logic [1:0] next_ptr(input logic [1:0] id);
        return (int'(id) == NREQ-1) ? 2'd0 : id + 2'd1;
    endfunction

    // Round-robin scan: first valid requester at or after rr_ptr wins.
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        any_req = 1'b0;
        win     = rr_ptr;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                win     = 2'(idx);
            end
        end
    end

    assign busy = (state != IDLE);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            gnt_id    <= 2'd0;
            m_valid   <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
            rsp_data  <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
`ifdef MULTI_ARB_TIMEOUT_EN
            timeout   <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            // Pulses are high for one cycle only.
            req_ready <= '0;
            rsp_valid <= '0;
`ifdef MULTI_ARB_TIMEOUT_EN
            timeout   <= 1'b0;
            wd_cnt    <= (state == ISSUE || state == WAIT) ? wd_cnt + 1'b1 : '0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        req_ready <= NREQ'(1) << win;
                        m_a       <= req_a[int'(win)*WIDTH +: WIDTH];
                        m_b       <= req_b[int'(win)*WIDTH +: WIDTH];
                        gnt_id    <= win;
                        m_valid   <= 1'b1;
                        state     <= ISSUE;
`ifdef MULTI_ARB_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end
                end
                ISSUE: begin
                    // m_valid is registered high here, so m_ready alone marks acceptance.
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= WAIT;
`ifdef MULTI_ARB_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (m_o_valid) begin
                        rsp_data  <= m_product;
                        rsp_valid <= NREQ'(1) << gnt_id;
                        state     <= RESP;
`ifdef MULTI_ARB_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end
                end
                RESP: begin
                    rr_ptr <= next_ptr(gnt_id);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef MULTI_ARB_TIMEOUT_EN
            // Watchdog abort overrides any normal transition taken this cycle.
            if ((state == ISSUE || state == WAIT) && wd_cnt == CW'(TO_LIMIT-1)) begin
                timeout   <= 1'b1;
                m_valid   <= 1'b0;
                rsp_valid <= '0;
                rr_ptr    <= next_ptr(gnt_id);
                state     <= IDLE;
                wd_cnt    <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_multi_arb.sv
// -----------------------------------------------------------------------------
// tb_multi_arb -- directed self-checking bench for multi_arb (WIDTH=4, NREQ=2)
// with a latency-4 multiplier core model. Outputs are sampled on the falling
// edge; inputs are driven on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_multi_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_a, req_b;
    logic [1:0] req_ready, rsp_valid;
    logic [7:0] rsp_data;
    logic       m_valid;
    logic [3:0] m_a, m_b;
    logic       m_ready;
    logic       m_o_valid;
    logic [7:0] m_product;
    logic       busy;
    logic [1:0] gnt_id;
`ifdef MULTI_ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_arb #(.WIDTH(4), .NREQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .m_valid   (m_valid),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_ready   (m_ready),
        .m_o_valid (m_o_valid),
        .m_product (m_product),
        .busy      (busy),
`ifdef MULTI_ARB_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .gnt_id    (gnt_id)
    );

    // Core model: fixed latency of 4 edges from acceptance to m_o_valid.
    logic [3:0] vpipe = '0;
    logic [7:0] ppipe [4];
    logic       core_en;
    logic       stray_ov;
    int         acc_cnt = 0;

    always @(posedge clk) begin
        vpipe    <= {vpipe[2:0], m_valid & m_ready};
        ppipe[0] <= 8'(m_a) * 8'(m_b);
        for (int i = 1; i < 4; i++) ppipe[i] <= ppipe[i-1];
        if (m_valid && m_ready) acc_cnt <= acc_cnt + 1;
    end

    assign m_o_valid = (vpipe[3] & core_en) | stray_ov;
    assign m_product = ppipe[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Step until a response appears (bounded); a missing response is a failure.
    task automatic wait_rsp(input string tag, output logic [1:0] vld, output logic [7:0] data);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == 2'b00 && n < 40);
        check({tag, "_rsp_seen"}, 32'(rsp_valid != 2'b00), 32'd1);
        vld  = rsp_valid;
        data = rsp_data;
    endtask

    logic [1:0] vld;
    logic [7:0] data;
    int         bad;
    int         acc_base;
    logic [1:0] exp_v [3] = '{2'b01, 2'b10, 2'b01};
    logic [7:0] exp_d [3] = '{8'd14, 8'd225, 8'd14};

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        m_ready = 1'b1; core_en = 1'b1; stray_ov = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_m_valid",   32'(m_valid),   32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_gnt_id",    32'(gnt_id),    32'd0);
        check("rst_m_ab",      32'({m_a, m_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 0: 3*5
        req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'b01);
        check("t1_gnt_id",    32'(gnt_id),    32'd0);
        check("t1_m_ab",      32'({m_a, m_b}), 32'h35);
        check("t1_m_valid",   32'(m_valid),   32'd1);
        check("t1_busy",      32'(busy),      32'd1);
        req_valid = 2'b10;            // requester 1 asks while busy, then gives up
        @(negedge clk);
        check("t1_ready_pulse", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        wait_rsp("t1", vld, data);
        check("t1_rsp_valid", 32'(vld),  32'b01);
        check("t1_rsp_data",  32'(data), 32'd15);
        @(negedge clk);
        check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("t1_busy_after", 32'(busy),     32'd0);
        check("t1_hold_data", 32'(rsp_data),  32'd15);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || req_ready != 2'b00 || rsp_valid != 2'b00) bad++;
        end
        check("t1_lost_request", 32'(bad), 32'd0);

        // Both requesters held: rotation 0,1,0 from a fresh pointer
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11; req_a = 8'hF2; req_b = 8'hF7;
        for (int i = 0; i < 3; i++) begin
            wait_rsp($sformatf("t2_%0d", i), vld, data);
            check($sformatf("t2_%0d_rsp_valid", i), 32'(vld),  32'(exp_v[i]));
            check($sformatf("t2_%0d_rsp_data", i),  32'(data), 32'(exp_d[i]));
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Core stalls in ISSUE: pointer now at 1, requester 1 asks 9*6
        m_ready = 1'b0;
        req_valid = 2'b10; req_a = 8'h90; req_b = 8'h60;
        acc_base = acc_cnt;
        @(negedge clk);
        check("t3_req_ready", 32'(req_ready), 32'b10);
        check("t3_gnt_id",    32'(gnt_id),    32'd1);
        req_valid = 2'b00;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_a !== 4'd9 || m_b !== 4'd6) bad++;
        end
        check("t3_stable", 32'(bad), 32'd0);
        check("t3_no_accept_yet", 32'(acc_cnt - acc_base), 32'd0);
        m_ready = 1'b1;
        wait_rsp("t3", vld, data);
        check("t3_rsp_valid", 32'(vld),  32'b10);
        check("t3_rsp_data",  32'(data), 32'd54);
        check("t3_one_accept", 32'(acc_cnt - acc_base), 32'd1);
        @(negedge clk);

        // Reset during WAIT discards the transaction
        req_valid = 2'b01; req_a = 8'h04; req_b = 8'h04;
        @(negedge clk);
        check("t4_req_ready", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        @(negedge clk);
        check("t4_in_wait", 32'({busy, m_valid}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_busy",     32'(busy),      32'd0);
        check("t4_rst_outputs",  32'({m_valid, req_ready, rsp_valid}), 32'd0);
        check("t4_rst_regs",     32'({rsp_data, m_a, m_b}), 32'd0);
        rst = 1'b0;
        stray_ov = 1'b1;
        @(negedge clk);
        stray_ov = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || busy) bad++;
        end
        check("t4_stray_ignored", 32'(bad), 32'd0);

`ifdef MULTI_ARB_TIMEOUT_EN
        // Core never answers: watchdog aborts 12 cycles after WAIT entry
        core_en = 1'b0;
        req_valid = 2'b01; req_a = 8'h01; req_b = 8'h01;
        @(negedge clk);
        check("t5_req_ready", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        @(negedge clk);               // first WAIT cycle
        begin
            int n = 0;
            bad = 0;
            do begin
                @(negedge clk);
                n++;
                if (rsp_valid != 2'b00) bad++;
            end while (!timeout && n < 30);
            check("t5_timeout_latency", 32'(n), 32'd12);
        end
        check("t5_timeout", 32'(timeout), 32'd1);
        check("t5_idle",    32'(busy),    32'd0);
        check("t5_no_rsp",  32'(bad),     32'd0);
        req_valid = 2'b11;
        @(negedge clk);
        check("t5_timeout_pulse", 32'(timeout), 32'd0);
        check("t5_next_grant",    32'(req_ready), 32'b10);
        req_valid = 2'b00;
        core_en = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running required finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
